// File: rtl/divider_arb_pkg.sv
// Shared types for the divider arbiter.
// FSM encoding and float width.
package divider_arb_pkg;

  localparam int FP_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_Z,
    RESP
  } divarb_state_t;

endpackage

// File: rtl/divider_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Search starts one past last_grant and wraps.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  int w_j;

  // Far-to-near scan: the nearest requester is written last and wins.
  always_comb begin
    grant_idx = '0;
    w_j       = 0;
    for (int k = N; k >= 1; k--) begin
      w_j = (int'(last_grant) + k) % N;
      if (req[IW'(w_j)]) grant_idx = IW'(w_j);
    end
    any_req      = |req;
    grant_onehot = any_req ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one stb/ack float divider among NUM_REQ clients.
// Round-robin grant, one division in flight.
module divider_arbiter
  import divider_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][FP_W-1:0]   req_a,
  input  logic [NUM_REQ-1:0][FP_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [FP_W-1:0]                resp_data,
  input  logic [NUM_REQ-1:0]             resp_ack,
  output logic                           busy,
  output logic [FP_W-1:0]                div_a,
  output logic                           div_a_stb,
  input  logic                           div_a_ack,
  output logic [FP_W-1:0]                div_b,
  output logic                           div_b_stb,
  input  logic                           div_b_ack,
  input  logic [FP_W-1:0]                div_z,
  input  logic                           div_z_stb,
  output logic                           div_z_ack
);

  divarb_state_t r_state;
  divarb_state_t w_next;

  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_last;
  logic [FP_W-1:0]    r_a;
  logic [FP_W-1:0]    r_b;
  logic [FP_W-1:0]    r_z;
  logic [NUM_REQ-1:0] r_ready;

  logic [NUM_REQ-1:0] w_grant_oh;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_any;
  logic               w_grab;
  logic               w_zcap;
  logic               w_done;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr (
    .req          (req_valid),
    .last_grant   (r_last),
    .grant_onehot (w_grant_oh),
    .grant_idx    (w_grant_idx),
    .any_req      (w_any)
  );

  assign w_grab = (r_state == IDLE) && w_any;
  assign w_zcap = (r_state == WAIT_Z) && div_z_stb;
  assign w_done = (r_state == RESP) && resp_ack[r_owner];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any)     w_next = SEND_A;
      SEND_A:  if (div_a_ack) w_next = SEND_B;
      SEND_B:  if (div_b_ack) w_next = WAIT_Z;
      WAIT_Z:  if (div_z_stb) w_next = RESP;
      RESP:    if (w_done)    w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  // req_ready is registered: it pulses in the first SEND_A cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);
      r_a     <= '0;
      r_b     <= '0;
      r_z     <= '0;
      r_ready <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= w_grab ? w_grant_oh : '0;
      if (w_grab) begin
        r_owner <= w_grant_idx;
        r_a     <= req_a[w_grant_idx];
        r_b     <= req_b[w_grant_idx];
      end
      if (w_zcap) r_z <= div_z;
      if (w_done) r_last <= r_owner;
    end
  end

  assign req_ready  = r_ready;
  assign busy       = (r_state != IDLE);
  assign div_a_stb  = (r_state == SEND_A);
  assign div_b_stb  = (r_state == SEND_B);
  assign div_a      = r_a;
  assign div_b      = r_b;
  assign div_z_ack  = w_zcap;
  assign resp_data  = r_z;
  assign resp_valid = (r_state == RESP) ?
                      (NUM_REQ'(1) << r_owner) : '0;

endmodule

// File: tb/tb_divider_arbiter.sv
// Self-checking bench: requester agent, divider model,
// round-robin and quotient reference checks.
module tb_divider_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready, resp_valid, resp_ack;
  logic [N-1:0][31:0] req_a, req_b;
  logic [31:0] resp_data, div_a, div_b, div_z;
  logic busy, div_a_stb, div_a_ack, div_b_stb, div_b_ack;
  logic div_z_stb, div_z_ack;

  int n_chk = 0;
  int n_fail = 0;

  divider_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_ack(resp_ack), .busy(busy),
    .div_a(div_a), .div_a_stb(div_a_stb), .div_a_ack(div_a_ack),
    .div_b(div_b), .div_b_stb(div_b_stb), .div_b_ack(div_b_ack),
    .div_z(div_z), .div_z_stb(div_z_stb), .div_z_ack(div_z_ack)
  );

  always #5 clk = ~clk;

  // Divider stand-in: exact for the test-plan pairs,
  // IEEE inf on zero divisor, a scramble otherwise.
  function automatic logic [31:0] ref_div(input logic [31:0] a,
                                          input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h3F800000 && b == 32'h40800000) return 32'h3E800000;
    if (b[30:0] == 31'd0) return {a[31] ^ b[31], 31'h7F800000};
    return a ^ {b[15:0], b[31:16]};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] pend,
                                 input int last);
    for (int k = 1; k <= N; k++)
      if (pend[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // ---------------- divider model ----------------
  int a_hold = 0, b_hold = 0, z_lat = 3;
  int m_ph = 0, m_cnt = 0, err_zack = 0;
  bit spur_en = 0, pa = 0, pb = 0, pz = 0;
  logic [31:0] m_a, m_b, pa_v, pb_v;

  initial begin : divmodel
    div_a_ack = 0; div_b_ack = 0; div_z_stb = 0; div_z = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ph = 0; m_cnt = 0; pa = 0; pb = 0; pz = 0;
        div_a_ack = 0; div_b_ack = 0; div_z_stb = 0; div_z = 0;
      end else begin
        if (pa) begin m_a = pa_v; m_ph = 1; m_cnt = 0; end
        if (pb) begin m_b = pb_v; m_ph = 2; m_cnt = 0; end
        if (pz) begin m_ph = 0; m_cnt = 0; end
        div_a_ack = 0; div_b_ack = 0; div_z_stb = 0;
        case (m_ph)
          0: begin
            if (div_a_stb) begin
              div_a_ack = (m_cnt >= a_hold); m_cnt++;
            end
            if (spur_en && $urandom_range(3) == 0) begin
              div_z_stb = 1; div_z = $urandom;
            end
          end
          1: begin
            if (div_b_stb) begin
              div_b_ack = (m_cnt >= b_hold); m_cnt++;
            end
            if (spur_en && $urandom_range(3) == 0) begin
              div_z_stb = 1; div_z = $urandom;
            end
          end
          2: begin
            m_cnt++;
            if (m_cnt >= z_lat) begin
              m_ph = 3; div_z = ref_div(m_a, m_b); div_z_stb = 1;
            end
          end
          default: div_z_stb = 1;
        endcase
        #1;
        pa = div_a_stb && div_a_ack; pa_v = div_a;
        pb = div_b_stb && div_b_ack; pb_v = div_b;
        pz = (m_ph == 3) && div_z_stb && div_z_ack;
        if (div_z_ack && m_ph != 3) err_zack++;
      end
    end
  end

  // ---------------- requester agent ----------------
  typedef struct { logic [31:0] a; logic [31:0] b; } op_t;
  typedef struct {
    int id; logic [N-1:0] snap; logic [31:0] a; logic [31:0] b;
    int t; bit stb;
  } grant_t;
  typedef struct { int id; logic [31:0] d; int t; } resp_t;

  op_t ops [N][$];
  grant_t g_log[$];
  resp_t r_log[$];
  logic [N-1:0] stray = '0, snap_prev = '0, rdy_prev = '0;
  int ack_dly = 0, ack_cnt = 0, cyc = 0;
  int err_ready = 0, err_hold = 0, model_last = N - 1;
  bit in_resp = 0;
  logic [31:0] hold_d;

  initial begin : agent
    grant_t g;
    resp_t r;
    req_valid = '0; req_a = '0; req_b = '0; resp_ack = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        req_valid = '0; resp_ack = '0; stray = '0;
        for (int i = 0; i < N; i++) ops[i].delete();
        in_resp = 0; snap_prev = '0; rdy_prev = '0;
      end else begin
        if (req_ready != '0) begin
          if (!$onehot(req_ready) || (req_ready & ~snap_prev) != '0
              || rdy_prev != '0) err_ready++;
          for (int i = 0; i < N; i++) begin
            if (req_ready[i] && req_valid[i]) begin
              g.id = i; g.snap = snap_prev; g.a = req_a[i];
              g.b = req_b[i]; g.t = cyc; g.stb = div_a_stb;
              g_log.push_back(g);
              req_valid[i] = 0;
              req_a[i] = $urandom; req_b[i] = $urandom;
              if (ops[i].size() > 0) void'(ops[i].pop_front());
            end
          end
        end
        rdy_prev = req_ready;
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] && !req_ready[i] && ops[i].size() > 0) begin
            req_valid[i] = 1;
            req_a[i] = ops[i][0].a; req_b[i] = ops[i][0].b;
          end
        end
        resp_ack = stray & ~resp_valid;
        stray = '0;
        if (resp_valid != '0) begin
          if (!$onehot(resp_valid)) err_ready++;
          if (!in_resp) begin
            in_resp = 1; hold_d = resp_data; ack_cnt = 0;
          end else if (resp_data !== hold_d) err_hold++;
          if (ack_cnt >= ack_dly) begin
            resp_ack = resp_ack | resp_valid;
            for (int i = 0; i < N; i++)
              if (resp_valid[i]) r.id = i;
            r.d = resp_data; r.t = cyc;
            r_log.push_back(r);
            in_resp = 0;
          end else ack_cnt++;
        end
        snap_prev = req_valid;
      end
    end
  end

  task automatic push_op(input int id, input logic [31:0] a,
                         input logic [31:0] b);
    op_t o;
    o.a = a; o.b = b;
    ops[id].push_back(o);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    bit pend;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      pend = 0;
      for (int j = 0; j < N; j++) if (ops[j].size() > 0) pend = 1;
      if (!busy && req_valid == '0 && !pend && resp_valid == '0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic clear_logs();
    g_log.delete(); r_log.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({req_ready, resp_valid, busy, div_a_stb, div_b_stb, div_z_ack}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0",
        {req_ready, resp_valid, busy, div_a_stb, div_b_stb, div_z_ack});
    end
    n_chk++;
    if ({div_a, div_b, resp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h expected 0",
               div_a, div_b, resp_data);
    end
    rst_n = 1;
    model_last = N - 1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_round_robin();
    int exp_ord [6] = '{0, 1, 3, 0, 1, 3};
    bit ok;
    int n2;
    clear_logs();
    for (int r = 0; r < 2; r++) begin
      push_op(0, $urandom, $urandom);
      push_op(1, $urandom, $urandom);
      push_op(3, $urandom, $urandom);
    end
    wait_idle(2000, ok);
    n_chk++;
    if (!ok || g_log.size() != 6 || r_log.size() != 6) begin
      n_fail++;
      $display("FAIL rr_count: ok=%0d grants=%0d resps=%0d expected 6",
               ok, g_log.size(), r_log.size());
    end
    n2 = 0;
    for (int k = 0; k < g_log.size() && k < 6; k++) begin
      n_chk++;
      if (g_log[k].id != exp_ord[k]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d",
                 k, g_log[k].id, exp_ord[k]);
      end
      n_chk++;
      if (g_log[k].id != rr_pick(g_log[k].snap, model_last)) begin
        n_fail++;
        $display("FAIL rr_model[%0d]: got %0d expected %0d", k,
                 g_log[k].id, rr_pick(g_log[k].snap, model_last));
      end
      model_last = g_log[k].id;
      if (g_log[k].id == 2) n2++;
      if (k < r_log.size()) begin
        n_chk++;
        if (r_log[k].id != g_log[k].id ||
            r_log[k].d !== ref_div(g_log[k].a, g_log[k].b)) begin
          n_fail++;
          $display("FAIL rr_data[%0d]: got id%0d %h expected id%0d %h",
                   k, r_log[k].id, r_log[k].d, g_log[k].id,
                   ref_div(g_log[k].a, g_log[k].b));
        end
      end
    end
    n_chk++;
    if (n2 != 0 || err_ready != 0) begin
      n_fail++;
      $display("FAIL rr_no_req2: grants2=%0d ready_err=%0d expected 0",
               n2, err_ready);
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    push_op(0, 32'h40C00000, 32'h40000000);
    wait_idle(200, ok);
    n_chk++;
    if (!ok || g_log.size() != 1 || r_log.size() != 1) begin
      n_fail++;
      $display("FAIL single_done: ok=%0d grants=%0d resps=%0d expected 1",
               ok, g_log.size(), r_log.size());
    end else begin
      n_chk++;
      if (g_log[0].id != 0 || g_log[0].stb != 1'b1) begin
        n_fail++;
        $display("FAIL single_grant: id=%0d stb=%0d expected 0 1",
                 g_log[0].id, g_log[0].stb);
      end
      n_chk++;
      if (r_log[0].d !== 32'h40400000) begin
        n_fail++;
        $display("FAIL single_data: got %h expected 40400000", r_log[0].d);
      end
      model_last = 0;
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL single_busy: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_stall();
    int a_cyc = 0, b_cyc = 0, a_bad = 0, b_bad = 0;
    bit ok;
    clear_logs();
    a_hold = 5; b_hold = 5;
    push_op(1, 32'h3F800000, 32'h40800000);
    for (int i = 0; i < 200 && r_log.size() == 0; i++) begin
      @(negedge clk);
      if (div_a_stb) begin
        a_cyc++; if (div_a !== 32'h3F800000) a_bad++;
      end
      if (div_b_stb) begin
        b_cyc++; if (div_b !== 32'h40800000) b_bad++;
      end
    end
    wait_idle(200, ok);
    a_hold = 0; b_hold = 0;
    n_chk++;
    if (a_cyc != 6 || b_cyc != 6) begin
      n_fail++;
      $display("FAIL stall_len: a=%0d b=%0d expected 6 6", a_cyc, b_cyc);
    end
    n_chk++;
    if (a_bad != 0 || b_bad != 0) begin
      n_fail++;
      $display("FAIL stall_stable: a_bad=%0d b_bad=%0d expected 0",
               a_bad, b_bad);
    end
    n_chk++;
    if (!ok || r_log.size() != 1 || r_log[0].d !== 32'h3E800000) begin
      n_fail++;
      $display("FAIL stall_data: ok=%0d n=%0d expected 3e800000",
               ok, r_log.size());
    end
    model_last = 1;
  endtask

  task automatic test_ack_delay();
    int rdy_seen = 0, idle_seen = 0, n_rv = 0;
    bit ok, got = 0;
    clear_logs();
    ack_dly = 10;
    push_op(0, 32'h40C00000, 32'h40000000);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (resp_valid[0]) got = 1;
    end
    push_op(2, 32'h3F800000, 32'h40800000);
    for (int i = 0; i < 10 && resp_valid[0]; i++) begin
      if (i == 3) stray = 4'b0100;
      if (i == 6) stray = 4'b1010;
      @(negedge clk);
      if (req_ready != '0) rdy_seen++;
      if (!busy) idle_seen++;
      if (resp_valid[0]) n_rv++;
    end
    wait_idle(400, ok);
    ack_dly = 0;
    n_chk++;
    if (!got || n_rv < 9 || rdy_seen != 0 || idle_seen != 0) begin
      n_fail++;
      $display("FAIL ackdly_hold: got=%0d rv=%0d rdy=%0d idle=%0d %s",
               got, n_rv, rdy_seen, idle_seen, "expected 1 >=9 0 0");
    end
    n_chk++;
    if (!ok || g_log.size() != 2 || r_log.size() != 2) begin
      n_fail++;
      $display("FAIL ackdly_count: ok=%0d g=%0d r=%0d expected 2",
               ok, g_log.size(), r_log.size());
    end else begin
      n_chk++;
      if (g_log[1].id != 2 || g_log[1].t <= r_log[0].t) begin
        n_fail++;
        $display("FAIL ackdly_order: id=%0d t=%0d expected 2 after %0d",
                 g_log[1].id, g_log[1].t, r_log[0].t);
      end
      n_chk++;
      if (r_log[0].d !== 32'h40400000 || r_log[1].d !== 32'h3E800000
          || err_hold != 0) begin
        n_fail++;
        $display("FAIL ackdly_data: got %h %h hold_err=%0d %s",
                 r_log[0].d, r_log[1].d, err_hold,
                 "expected 40400000 3e800000 0");
      end
    end
    model_last = 2;
  endtask

  task automatic test_div_zero();
    bit ok;
    clear_logs();
    push_op(3, 32'h3F800000, 32'h00000000);
    wait_idle(200, ok);
    n_chk++;
    if (!ok || r_log.size() != 1 || r_log[0].d !== 32'h7F800000) begin
      n_fail++;
      $display("FAIL div_zero: ok=%0d n=%0d expected 7f800000",
               ok, r_log.size());
    end
    model_last = 3;
  endtask

  task automatic test_random();
    bit ok;
    int bad_rr = 0, bad_d = 0;
    clear_logs();
    spur_en = 1;
    for (int i = 0; i < 16; i++)
      push_op(int'($urandom_range(N - 1)), $urandom, $urandom);
    ok = 0;
    for (int c = 0; c < 6000 && !ok; c++) begin
      if ($urandom_range(7) == 0) begin
        a_hold = $urandom_range(2); b_hold = $urandom_range(2);
        z_lat = 1 + $urandom_range(3); ack_dly = $urandom_range(3);
      end
      if ($urandom_range(5) == 0) stray = 4'($urandom_range(15));
      wait_idle(1, ok);
    end
    spur_en = 0; a_hold = 0; b_hold = 0; z_lat = 3; ack_dly = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (!ok || g_log.size() != 16 || r_log.size() != 16) begin
      n_fail++;
      $display("FAIL rand_count: ok=%0d g=%0d r=%0d expected 16",
               ok, g_log.size(), r_log.size());
    end
    for (int k = 0; k < g_log.size() && k < r_log.size(); k++) begin
      if (g_log[k].id != rr_pick(g_log[k].snap, model_last)) bad_rr++;
      model_last = g_log[k].id;
      if (r_log[k].id != g_log[k].id ||
          r_log[k].d !== ref_div(g_log[k].a, g_log[k].b)) bad_d++;
    end
    n_chk++;
    if (bad_rr != 0) begin
      n_fail++; $display("FAIL rand_rr: bad=%0d expected 0", bad_rr);
    end
    n_chk++;
    if (bad_d != 0) begin
      n_fail++; $display("FAIL rand_data: bad=%0d expected 0", bad_d);
    end
    n_chk++;
    if (err_ready != 0 || err_hold != 0 || err_zack != 0) begin
      n_fail++;
      $display("FAIL rand_proto: rdy=%0d hold=%0d zack=%0d expected 0",
               err_ready, err_hold, err_zack);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, hit = 0;
    clear_logs();
    push_op(0, $urandom, $urandom);
    wait_idle(200, ok);
    push_op(1, 32'h40C00000, 32'h40000000);
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (m_ph == 2) hit = 1;
    end
    #2 rst_n = 0;
    #1;
    n_chk++;
    if (!hit || {req_ready, resp_valid, busy, div_a_stb, div_b_stb,
                 div_z_ack} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_ctrl: hit=%0d busy=%b stb=%b%b expected 1 0 00",
               hit, busy, div_a_stb, div_b_stb);
    end
    n_chk++;
    if ({div_a, div_b, resp_data} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_data: got %h %h %h expected 0",
               div_a, div_b, resp_data);
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    clear_logs();
    push_op(0, 32'h40C00000, 32'h40000000);
    push_op(2, 32'h3F800000, 32'h40800000);
    wait_idle(400, ok);
    n_chk++;
    if (!ok || g_log.size() != 2 || r_log.size() != 2) begin
      n_fail++;
      $display("FAIL rstmid_count: ok=%0d g=%0d expected 2",
               ok, g_log.size());
    end else begin
      n_chk++;
      if (g_log[0].id != 0 || g_log[1].id != 2) begin
        n_fail++;
        $display("FAIL rstmid_prio: got %0d,%0d expected 0,2",
                 g_log[0].id, g_log[1].id);
      end
      n_chk++;
      if (r_log[0].d !== 32'h40400000) begin
        n_fail++;
        $display("FAIL rstmid_data2: got %h expected 40400000",
                 r_log[0].d);
      end
    end
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    test_reset();
    test_round_robin();
    test_single();
    test_stall();
    test_ack_delay();
    test_div_zero();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one single-precision `divider` instance (three-channel stb/ack interface: a, b, z) among NUM_REQ requesters.
- Requesters are perspective-divide clients such as the coordinate transformer and the rasterizer's barycentric/normalization units.
- Round-robin grant; one division in flight at a time.
- Operands are latched at grant; the divider handshake is sequenced a → b → z; the result is returned to the owning requester with a valid/ack handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(NUM_REQ), width of the owner index.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low; clock clk
- req_valid  in  NUM_REQ  per-requester request; held high until req_ready
- req_a  in  [NUM_REQ][32]  dividend, IEEE-754 single
- req_b  in  [NUM_REQ][32]  divisor, IEEE-754 single
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester
- resp_valid  out  NUM_REQ  one-hot; result available for the owner
- resp_data  out  32  quotient, shared by all requesters; qualify with resp_valid
- resp_ack  in  NUM_REQ  owner consumes the result
- busy  out  1  high whenever the state is not IDLE
- div_a  out  32  to divider input_a
- div_a_stb  out  1  to divider input_a_stb
- div_a_ack  in  1  from divider input_a_ack
- div_b  out  32  to divider input_b
- div_b_stb  out  1  to divider input_b_stb
- div_b_ack  in  1  from divider input_b_ack
- div_z  in  32  from divider output_z
- div_z_stb  in  1  from divider output_z_stb
- div_z_ack  out  1  to divider output_z_ack

Behaviour:
- Reset values:
  - state = IDLE.
  - req_ready, resp_valid, busy, div_a_stb, div_b_stb, div_z_ack = 0.
  - div_a, div_b, resp_data = 0.
  - Priority pointer last_grant = NUM_REQ-1, so requester 0 wins first.
- State machine states: IDLE, SEND_A, SEND_B, WAIT_Z, RESP.
- IDLE:
  - If any req_valid is high, select the first set bit searching from last_grant+1 with wrap-around.
  - Latch owner, req_a[owner] into the a register and req_b[owner] into the b register.
  - Pulse req_ready[owner] for exactly this cycle.
  - Next state = SEND_A.
  - If no request is pending, stay in IDLE.
- SEND_A:
  - div_a_stb = 1 and div_a = latched a.
  - On a clock edge where div_a_ack = 1: next state = SEND_B and div_a_stb drops.
- SEND_B:
  - div_b_stb = 1 and div_b = latched b.
  - On a clock edge where div_b_ack = 1: next state = WAIT_Z.
- WAIT_Z:
  - div_z_ack = (state == WAIT_Z) && div_z_stb, combinational.
  - On that edge: capture div_z into resp_data; next state = RESP.
- RESP:
  - resp_valid[owner] = 1; resp_data is held stable.
  - On a clock edge where resp_ack[owner] = 1: next state = IDLE and last_grant = owner.
- Stb/ack outputs (div_a_stb, div_b_stb, req_ready, resp_valid) are decoded from registered state; no combinational path from req_valid to div_*.
- Only div_z_ack is combinational on div_z_stb.
- Latency:
  - Request accept to div_a_stb = 1 cycle.
  - Minimum grant-to-grant = 4 cycles + divider compute time + resp_ack delay.
  - At least one IDLE cycle separates operations.
- Boundary conditions:
  - Simultaneous requests: round-robin order; a continuously requesting client cannot starve the others.
  - req_valid changing after the grant cycle has no effect; operands are already latched.
  - resp_ack from a non-owner, or outside RESP, is ignored.
  - req_valid raised during a busy operation waits; it is not accepted until IDLE.
  - div_z_stb outside WAIT_Z is ignored; div_z_ack stays 0.
  - Divide-by-zero and NaN are passed through unchanged: resp_data is whatever the divider returns, with no special casing.
  - Reset mid-operation returns every output to its reset value immediately. The divider is reset by the same rst_n (its `rst` pin is driven with ~rst_n), so no handshake is left dangling.

Decomposition:
- Package `divider_arb_pkg`:
  - typedef enum logic [2:0] divarb_state_t {IDLE, SEND_A, SEND_B, WAIT_Z, RESP}.
  - localparam FP_W = 32.
- Sub-module `rr_arbiter`: parameter N, ports (req[N], last_grant, grant_onehot[N], grant_idx, any_req), purely combinational.
- Top level holds the FSM, the operand/result registers and the pointer update.

Test Plan:
- Single request, div behavioural model with 3-cycle compute: req 0 with a = 0x40C00000 (6.0), b = 0x40000000 (2.0).
  → req_ready[0] pulses one cycle; resp_valid[0] with resp_data = 0x40400000 (3.0); busy low after resp_ack.
- Requesters 0, 1, 3 all asserting from the same cycle, each re-asserting after its response.
  → grant order 0, 1, 3, 0, 1, 3; requester 2 never granted; one req_ready pulse per grant.
- Model holds div_a_ack and div_b_ack low for 5 cycles each.
  → div_a_stb and div_b_stb stay high with div_a = 0x3F800000 and div_b = 0x40800000 (1.0/4.0) stable; result 0x3E800000.
- resp_ack delayed 10 cycles while requester 2 pends.
  → resp_data is held; no new grant; a non-owner resp_ack pulse is ignored; requester 2 is granted only after the owner's ack.
- Divisor 0x00000000, dividend 0x3F800000.
  → resp_data equals the divider's output (model returns 0x7F800000), with no stall or hang.
- rst_n asserted asynchronously during WAIT_Z.
  → all outputs 0 within the reset assertion; after release, requester 0 has priority and a fresh 6.0/2.0 completes correctly.
